// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if
// Pipeline <-> CP0 bundle for the exception/interrupt controller.
//   master : pipeline side. It drives the M-stage PC, exception code, branch-delay
//            flag, external interrupt lines, mtc0/eret controls and the CP0 address
//            and write data. It receives the read data, the flush request, EPC and
//            the handler entry address.
//   slave  : the CP0 controller (cp0_exc_ctrl).
interface cp0_exc_ctrl_if;
    logic [31:0] pc_m;
    logic [4:0]  exc_code_m;
    logic        bd_m;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret_m;
    logic [31:0] cp0_rdata;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] exc_entry;

    modport master (
        output pc_m, exc_code_m, bd_m, hw_int, cp0_we, cp0_addr, cp0_wdata, eret_m,
        input  cp0_rdata, int_req, epc_out, exc_entry
    );

    modport slave (
        input  pc_m, exc_code_m, bd_m, hw_int, cp0_we, cp0_addr, cp0_wdata, eret_m,
        output cp0_rdata, int_req, epc_out, exc_entry
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
// Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline.
// The block evaluates the exception and interrupt conditions of the M-stage
// instruction. It raises int_req, the flush request to the pipeline registers
// and the PC select. It also holds SR(12), Cause(13), EPC(14) and PRId(15).
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : cp0_exc_ctrl_if.slave. It carries the M-stage inputs, the mtc0/mfc0
//           access, cp0_rdata, int_req, epc_out and exc_entry.
// Optional feature: define CP0_TIMER_EN to add Count(9) and Compare(11). The
// timer interrupt ORs into IP[15].
module cp0_exc_ctrl #(
    parameter logic [31:0] ENTRY = 32'h0000_4180,
    parameter logic [31:0] PRID  = 32'h0000_4D49
) (
    input logic            clk,
    input logic            reset,
    cp0_exc_ctrl_if.slave  bus
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic        timer_irq;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_irq_q, timer_irq_d;
    assign timer_irq = timer_irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    logic irq, exc, req, mtc0_ok;

    // IP is the registered copy of the interrupt lines. A level must therefore be
    // present for a full cycle before it can request service.
    assign irq     = (|(ip_q & im_q)) & ie_q & ~exl_q;
    assign exc     = (bus.exc_code_m != 5'd0) & ~exl_q;
    assign req     = irq | exc;
    // An mtc0 or eret that coincides with req is the instruction being flushed.
    assign mtc0_ok = bus.cp0_we & ~req;

    assign bus.int_req   = req;
    assign bus.epc_out   = epc_q;
    assign bus.exc_entry = ENTRY;

    // The read returns the pre-update contents. mtc0->mfc0 forwarding is handled in the pipeline.
    always_comb begin
        case (bus.cp0_addr)
            5'd12:   bus.cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13:   bus.cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            5'd14:   bus.cp0_rdata = epc_q;
            5'd15:   bus.cp0_rdata = PRID;
`ifdef CP0_TIMER_EN
            5'd9:    bus.cp0_rdata = count_q;
            5'd11:   bus.cp0_rdata = compare_q;
`endif
            default: bus.cp0_rdata = 32'd0;
        endcase
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = {bus.hw_int[5] | timer_irq, bus.hw_int[4:0]};

        if (req) begin
            exl_d      = 1'b1;
            exc_code_d = irq ? 5'd0 : bus.exc_code_m;
            bd_d       = bus.bd_m;
            epc_d      = (bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m) & 32'hFFFF_FFFC;
        end else begin
            if (bus.eret_m) begin
                exl_d = 1'b0;
            end
            if (mtc0_ok) begin
                case (bus.cp0_addr)
                    5'd12: begin
                        im_d  = bus.cp0_wdata[15:10];
                        exl_d = bus.cp0_wdata[1];
                        ie_d  = bus.cp0_wdata[0];
                    end
                    5'd14:   epc_d = bus.cp0_wdata & 32'hFFFF_FFFC;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    always_comb begin
        count_d     = count_q + 32'd1;
        compare_d   = compare_q;
        timer_irq_d = timer_irq_q;
        if (mtc0_ok && bus.cp0_addr == 5'd9) begin
            count_d = bus.cp0_wdata;
        end
        if (mtc0_ok && bus.cp0_addr == 5'd11) begin
            compare_d   = bus.cp0_wdata;
            timer_irq_d = 1'b0;
        end else if (count_q == compare_q && compare_q != 32'd0) begin
            timer_irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            timer_irq_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_irq_q <= timer_irq_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;
    localparam logic [31:0] ENTRY = 32'h0000_4180;
    localparam logic [31:0] PRID  = 32'h0000_4D49;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cp0_exc_ctrl_if bus();
    cp0_exc_ctrl #(.ENTRY(ENTRY), .PRID(PRID)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] rdata;
        logic        int_req;
        logic [31:0] epc;
        logic [4:0]  addr;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference state kept as whole 32-bit register images.
    logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
    logic        m_tirq;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return PRID;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] pc, input logic [4:0] code,
                        input logic bd, input logic [5:0] hw, input logic we,
                        input logic [4:0] addr, input logic [31:0] wdata, input logic eret);
        exp_t e;
        logic irq, exc, req;
        logic [31:0] ipw;
        @(posedge clk);
        #1;
        reset          = rst;
        bus.pc_m       = pc;
        bus.exc_code_m = code;
        bus.bd_m       = bd;
        bus.hw_int     = hw;
        bus.cp0_we     = we;
        bus.cp0_addr   = addr;
        bus.cp0_wdata  = wdata;
        bus.eret_m     = eret;

        irq = ((m_cause & m_sr & 32'h0000_FC00) != 0) && m_sr[0] && !m_sr[1];
        exc = (code != 5'd0) && !m_sr[1];
        req = irq || exc;
        e.rdata   = m_read(addr);
        e.int_req = req;
        e.epc     = m_epc;
        e.addr    = addr;
        sb.push_back(e);

        if (rst) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_tirq = 0;
        end else begin
            ipw = {16'd0, hw, 10'd0};
`ifdef CP0_TIMER_EN
            if (m_tirq) ipw = ipw | 32'h0000_8000;
`endif
            m_cause = (m_cause & ~32'h0000_FC00) | ipw;
`ifdef CP0_TIMER_EN
            if (we && !req && addr == 5'd11) m_tirq = 1'b0;
            else if (m_count == m_compare && m_compare != 0) m_tirq = 1'b1;
            if (we && !req && addr == 5'd9) m_count = wdata;
            else m_count = m_count + 1;
            if (we && !req && addr == 5'd11) m_compare = wdata;
`endif
            if (req) begin
                m_sr    = m_sr | 32'h2;
                m_cause = (m_cause & ~32'h8000_007C) | (bd ? 32'h8000_0000 : 32'd0)
                          | (irq ? 32'd0 : (32'(code) * 4));
                m_epc   = (bd ? pc - 4 : pc) & ~32'h3;
            end else begin
                if (eret) m_sr = m_sr & ~32'h2;
                if (we && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
                if (we && addr == 5'd14) m_epc = wdata & ~32'h3;
            end
        end
    endtask

    task automatic idle(input logic [4:0] addr, input logic [5:0] hw);
        step(1'b0, 32'h0, 5'd0, 1'b0, hw, 1'b0, addr, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] d, input logic [5:0] hw);
        step(1'b0, 32'h0, 5'd0, 1'b0, hw, 1'b1, addr, d, 1'b0);
    endtask

    task automatic do_eret(input logic [4:0] addr, input logic [5:0] hw);
        step(1'b0, 32'h0, 5'd0, 1'b0, hw, 1'b0, addr, 32'h0, 1'b1);
    endtask

    // Monitor: DUT presents outputs every cycle; compare mid-cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("rdata[%0d]", e.addr), bus.cp0_rdata, e.rdata);
                chk("int_req", {31'd0, bus.int_req}, {31'd0, e.int_req});
                chk("epc_out", bus.epc_out, e.epc);
                chk("exc_entry", bus.exc_entry, ENTRY);
            end
        end
    end

    initial begin
        logic [4:0] alist [8];
        logic [31:0] r;
        int op;
        alist = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd12};

        reset = 1'b1;
        bus.pc_m = 0; bus.exc_code_m = 0; bus.bd_m = 0; bus.hw_int = 0;
        bus.cp0_we = 0; bus.cp0_addr = 0; bus.cp0_wdata = 0; bus.eret_m = 0;
        m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_tirq = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // The driver now syncs to the next edge, so the model is taken from that point.
        m_count = 32'd0;

        // Reset state, and masked interrupts with SR=0.
        idle(5'd0, 6'h3F);
        idle(5'd12, 6'h3F);
        idle(5'd13, 6'h3F);
        idle(5'd14, 6'h3F);
        idle(5'd15, 6'h3F);

        // Enable everything and raise hw_int[2].
        wr(5'd12, 32'h0000_FC01, 6'h00);
        idle(5'd13, 6'h04);
        idle(5'd13, 6'h04);
        idle(5'd13, 6'h04);
        idle(5'd12, 6'h04);
        do_eret(5'd12, 6'h00);
        idle(5'd12, 6'h00);

        // Overflow in a branch delay slot.
        step(1'b0, 32'h3010, 5'd12, 1'b1, 6'h00, 1'b0, 5'd13, 32'h0, 1'b0);
        idle(5'd14, 6'h00);
        idle(5'd13, 6'h00);
        do_eret(5'd14, 6'h00);
        idle(5'd12, 6'h00);

        // Interrupt and exception together, with a concurrent mtc0 EPC that gets flushed.
        idle(5'd13, 6'h04);
        step(1'b0, 32'h5000, 5'd4, 1'b0, 6'h04, 1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0);
        idle(5'd14, 6'h04);
        idle(5'd13, 6'h04);
        // eret with interrupt still pending: exl clears, then eret+irq re-enters.
        do_eret(5'd12, 6'h04);
        do_eret(5'd12, 6'h04);
        idle(5'd12, 6'h00);
        idle(5'd13, 6'h00);

        // Reset together with an exception.
        do_eret(5'd12, 6'h00);
        step(1'b1, 32'h7000, 5'd10, 1'b0, 6'h00, 1'b0, 5'd14, 32'h0, 1'b0);
        idle(5'd14, 6'h00);
        idle(5'd12, 6'h00);

`ifdef CP0_TIMER_EN
        wr(5'd12, 32'h0000_8001, 6'h00);
        wr(5'd9, 32'h0, 6'h00);
        wr(5'd11, 32'h5, 6'h00);
        for (int i = 0; i < 10; i++) idle(5'd9, 6'h00);
        idle(5'd13, 6'h00);
        wr(5'd11, 32'h0, 6'h00);
        do_eret(5'd13, 6'h00);
        idle(5'd13, 6'h00);
        idle(5'd13, 6'h00);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        rst, bd, we, eret;
            logic [4:0]  code, addr;
            logic [5:0]  hw;
            logic [31:0] pc, wd;
            rst  = ($urandom_range(0, 199) == 0);
            code = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            r    = $urandom;
            hw   = ($urandom_range(0, 3) == 0) ? r[5:0] : 6'd0;
            pc   = $urandom & 32'hFFFF_FFFC;
            bd   = 1'($urandom_range(0, 1));
            op   = $urandom_range(0, 9);
            eret = (op < 2);
            we   = (op == 2 || op == 3);
            addr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : alist[$urandom_range(0, 7)];
            wd   = $urandom;
            if (we && addr == 5'd12 && $urandom_range(0, 1) == 1) wd = wd & 32'hFFFF_FFFD;
            if (we && addr == 5'd11) wd = wd & 32'h0000_003F;
            step(rst, pc, code, bd, hw, we, addr, wd, eret);
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
